// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC CPU: control-bus encodings used by
// both the controller and the datapath, plus the datapath geometry.
package cpu_pkg;

    localparam int DW   = 16;
    localparam int NREG = 8;

    typedef enum logic [1:0] {
        RD   = 2'b00,
        RM   = 2'b01,
        RN   = 2'b10,
        NONE = 2'b11
    } reg_sel_t;

    typedef enum logic [1:0] {
        WB_C     = 2'b00,
        WB_PC    = 2'b01,
        WB_IMM8  = 2'b10,
        WB_MDATA = 2'b11
    } wb_sel_t;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        MVN = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        NOSH = 2'b00,
        LSL  = 2'b01,
        LSR  = 2'b10,
        ASR  = 2'b11
    } shift_t;

endpackage

// File: rtl/datapath_regfile.sv
// Register file: NREG x DW, combinational read, synchronous write.
// A single index serves both read and write, so a same-cycle read of the
// register being written returns the old contents.
//   clk, rst : clock, synchronous active-high reset (clears all registers)
//   we       : write enable
//   addr     : register index
//   wdata    : write data
//   rdata    : read data (combinational)
module regfile #(
    parameter int DW   = 16,
    parameter int NREG = 8,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [NREG-1:0][DW-1:0] regs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
        end else if (we) begin
            regs_q[addr] <= wdata;
        end
    end

    assign rdata = regs_q[addr];

endmodule

// File: rtl/datapath.sv
// Execution datapath: register file, operand registers A/B, shifter on B,
// ALU, result register C and status flags Z/N/V. Every control input is
// acted on in the cycle it is asserted; sequencing belongs to the controller.
//   clk, rst           : clock, synchronous active-high reset
//   ir                 : instruction word (register numbers, immediates, op)
//   mdata, pc          : write-back sources (RAM data, program counter)
//   reg_sel, wb_sel    : register index select, write-back source select
//   w_en               : register-file write enable
//   en_A/B/C/en_status : load enables
//   sel_A, sel_B       : ALU input muxes (zero / sximm5 overrides)
//   datapath_out       : C register
//   Z, N, V            : status flags
module datapath #(
    parameter int DW   = cpu_pkg::DW,
    parameter int NREG = cpu_pkg::NREG
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   ir,
    input  logic [DW-1:0] mdata,
    input  logic [7:0]    pc,
    input  logic [1:0]    reg_sel,
    input  logic [1:0]    wb_sel,
    input  logic          w_en,
    input  logic          en_A,
    input  logic          en_B,
    input  logic          en_C,
    input  logic          en_status,
    input  logic          sel_A,
    input  logic          sel_B,
    output logic [DW-1:0] datapath_out,
    output logic          Z,
    output logic          N,
    output logic          V
);
    import cpu_pkg::*;

    localparam int AW = $clog2(NREG);

    logic [AW-1:0] rn, rd, rm, idx;
    logic [1:0]    alu_op, shift;
    logic [DW-1:0] sximm8, sximm5;
    logic [DW-1:0] rf_wdata, rf_rdata;
    logic          rf_we;

    logic [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic          z_q, z_d, n_q, n_d, v_q, v_d;
    logic [DW-1:0] b_sh, ain, bin, alu_res;
    logic          alu_v;

    // Instruction field decode
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];
    assign alu_op = ir[12:11];
    assign shift  = ir[4:3];
    assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};
    assign sximm5 = {{(DW-5){ir[4]}}, ir[4:0]};

    always_comb begin
        idx = rd;
        case (reg_sel_t'(reg_sel))
            RN:      idx = rn;
            RM:      idx = rm;
            RD:      idx = rd;
            default: idx = rd;  // NONE: read data unused, write suppressed
        endcase
    end

    // NONE gates the write regardless of w_en
    assign rf_we = w_en && (reg_sel_t'(reg_sel) != NONE);

    always_comb begin
        rf_wdata = c_q;
        case (wb_sel_t'(wb_sel))
            WB_C:     rf_wdata = c_q;
            WB_PC:    rf_wdata = {{(DW-8){1'b0}}, pc};
            WB_IMM8:  rf_wdata = sximm8;
            WB_MDATA: rf_wdata = mdata;
            default:  rf_wdata = c_q;
        endcase
    end

    regfile #(.DW(DW), .NREG(NREG)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (rf_we),
        .addr  (idx),
        .wdata (rf_wdata),
        .rdata (rf_rdata)
    );

    // Shifter on B only
    always_comb begin
        b_sh = b_q;
        case (shift_t'(shift))
            NOSH:    b_sh = b_q;
            LSL:     b_sh = {b_q[DW-2:0], 1'b0};
            LSR:     b_sh = {1'b0, b_q[DW-1:1]};
            ASR:     b_sh = {b_q[DW-1], b_q[DW-1:1]};
            default: b_sh = b_q;
        endcase
    end

    assign ain = sel_A ? '0 : a_q;
    assign bin = sel_B ? sximm5 : b_sh;

    // Signed overflow: ADD overflows when operands agree in sign and the
    // result does not; SUB when operands differ and the result leaves Ain's sign.
    always_comb begin
        alu_res = '0;
        alu_v   = 1'b0;
        case (alu_op_t'(alu_op))
            ADD: begin
                alu_res = ain + bin;
                alu_v   = (ain[DW-1] == bin[DW-1]) && (alu_res[DW-1] != ain[DW-1]);
            end
            SUB: begin
                alu_res = ain - bin;
                alu_v   = (ain[DW-1] != bin[DW-1]) && (alu_res[DW-1] != ain[DW-1]);
            end
            AND:     alu_res = ain & bin;
            MVN:     alu_res = ~bin;
            default: alu_res = '0;
        endcase
    end

    assign a_d = en_A ? rf_rdata : a_q;
    assign b_d = en_B ? rf_rdata : b_q;
    assign c_d = en_C ? alu_res  : c_q;
    assign z_d = en_status ? (alu_res == '0) : z_q;
    assign n_d = en_status ? alu_res[DW-1]   : n_q;
    assign v_d = en_status ? alu_v           : v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            z_q <= z_d;
            n_q <= n_d;
            v_q <= v_d;
        end
    end

    assign datapath_out = c_q;
    assign Z = z_q;
    assign N = n_q;
    assign V = v_q;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic [15:0] mdata;
    logic [7:0]  pc;
    logic [1:0]  reg_sel, wb_sel;
    logic        w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
    logic [15:0] datapath_out;
    logic        Z, N, V;

    datapath dut (
        .clk(clk), .rst(rst), .ir(ir), .mdata(mdata), .pc(pc),
        .reg_sel(reg_sel), .wb_sel(wb_sel), .w_en(w_en),
        .en_A(en_A), .en_B(en_B), .en_C(en_C), .en_status(en_status),
        .sel_A(sel_A), .sel_B(sel_B),
        .datapath_out(datapath_out), .Z(Z), .N(N), .V(V)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          due;
        logic [15:0] c;
        logic        z, n, v;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    logic fz = 1'b0, fn = 1'b0, fv = 1'b0;  // expected flag state

    // Monitor: compare the head expectation once its cycle has arrived
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            if (datapath_out !== e.c || Z !== e.z || N !== e.n || V !== e.v) begin
                failures++;
                $display("FAIL %s: got C=%h ZNV=%b%b%b, want C=%h ZNV=%b%b%b",
                         e.name, datapath_out, Z, N, V, e.c, e.z, e.n, e.v);
            end
        end
    end

    task automatic idle();
        rst = 1'b0; ir = '0; mdata = '0; pc = '0;
        reg_sel = NONE; wb_sel = WB_C; w_en = 1'b0;
        en_A = 1'b0; en_B = 1'b0; en_C = 1'b0; en_status = 1'b0;
        sel_A = 1'b0; sel_B = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_c(input string name, input logic [15:0] c);
        exp_t e;
        e.name = name; e.due = cyc; e.c = c; e.z = fz; e.n = fn; e.v = fv;
        sbq.push_back(e);
    endtask

    task automatic write_imm(input logic [2:0] r, input logic [7:0] imm);
        ir = {5'b11010, r, imm}; reg_sel = RN; wb_sel = WB_IMM8; w_en = 1'b1;
        step();
    endtask

    task automatic write_md(input logic [2:0] r, input logic [15:0] v);
        ir = {5'b0, r, 8'b0}; reg_sel = RN; wb_sel = WB_MDATA; mdata = v; w_en = 1'b1;
        step();
    endtask

    task automatic load_A(input logic [2:0] r);
        ir = {5'b0, r, 8'b0}; reg_sel = RN; en_A = 1'b1;
        step();
    endtask

    task automatic load_B(input logic [2:0] r);
        ir = {13'b0, r}; reg_sel = RM; en_B = 1'b1;
        step();
    endtask

    task automatic exec(input logic [1:0] op, input logic [4:0] low5,
                        input logic sa, input logic sb, input logic ec, input logic es);
        ir = {3'b000, op, 6'b0, low5};
        sel_A = sa; sel_B = sb; en_C = ec; en_status = es;
        step();
    endtask

    // C <= Rr through A + 0
    task automatic read_reg(input string name, input logic [2:0] r, input logic [15:0] v);
        load_A(r);
        exec(ADD, 5'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_c(name, v);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        expect_c("reset", 16'h0000);
        step();

        // imm8 write-back, ir = 0xD37F
        write_imm(3'd3, 8'h7F);
        read_reg("r3_imm8", 3'd3, 16'h007F);
        read_reg("r0_after_reset", 3'd0, 16'h0000);

        // ADD 5 + 0xFFFD
        write_imm(3'd1, 8'h05);
        write_imm(3'd2, 8'hFD);
        load_A(3'd1);
        load_B(3'd2);
        exec(ADD, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_c("add", 16'h0002);
        ir = {8'b0, 3'd5, 5'b0}; reg_sel = RD; wb_sel = WB_C; w_en = 1'b1;
        step();
        read_reg("wb_c_rd", 3'd5, 16'h0002);

        // CMP 0x7FFF - 0xFFFF
        write_md(3'd1, 16'h7FFF);
        write_imm(3'd2, 8'hFF);
        load_A(3'd1);
        load_B(3'd2);
        fz = 1'b0; fn = 1'b1; fv = 1'b1;
        exec(SUB, 5'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_c("cmp_ovf", 16'h8000);

        // CMP equal
        write_md(3'd1, 16'h1234);
        load_A(3'd1);
        load_B(3'd1);
        fz = 1'b1; fn = 1'b0; fv = 1'b0;
        exec(SUB, 5'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_c("cmp_eq", 16'h0000);

        // Shifts of 0x8001 with A forced to 0
        write_md(3'd2, 16'h8001);
        load_B(3'd2);
        exec(ADD, {LSL, 3'b0}, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_c("lsl", 16'h0002);
        exec(ADD, {LSR, 3'b0}, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_c("lsr", 16'h4000);
        exec(ADD, {ASR, 3'b0}, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_c("asr", 16'hC000);

        // MVN and AND (flags not loaded)
        exec(MVN, {NOSH, 3'b0}, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_c("mvn", 16'h7FFE);
        write_md(3'd1, 16'hF0F1);
        load_A(3'd1);
        exec(AND, 5'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_c("and", 16'h8001);

        // LDR-style address, then mdata write-back to Rd
        write_imm(3'd1, 8'h10);
        load_A(3'd1);
        exec(ADD, 5'b11110, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_c("ldr_addr", 16'h000E);
        ir = {8'b0, 3'd6, 5'b0}; reg_sel = RD; wb_sel = WB_MDATA; mdata = 16'hBEEF; w_en = 1'b1;
        step();
        read_reg("wb_mdata", 3'd6, 16'hBEEF);

        // pc write-back, zero-extended
        ir = {5'b0, 3'd7, 8'b0}; reg_sel = RN; wb_sel = WB_PC; pc = 8'hA5; w_en = 1'b1;
        step();
        read_reg("wb_pc", 3'd7, 16'h00A5);

        // reg_sel=NONE blocks the write: Rn=3, Rd=2, Rm=5 all untouched
        ir = {5'b0, 3'd3, 8'h55}; reg_sel = NONE; wb_sel = WB_IMM8; w_en = 1'b1;
        step();
        read_reg("none_r3", 3'd3, 16'h007F);
        read_reg("none_r2", 3'd2, 16'h8001);

        // Read-before-write on R4
        write_imm(3'd4, 8'h11);
        ir = {5'b0, 3'd4, 8'h22}; reg_sel = RN; wb_sel = WB_IMM8; w_en = 1'b1; en_A = 1'b1;
        step();
        exec(ADD, 5'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        expect_c("rbw_old", 16'h0011);
        read_reg("rbw_new", 3'd4, 16'h0022);

        // Reset dominates en_C / en_status
        write_imm(3'd1, 8'h80);
        load_A(3'd1);
        rst = 1'b1;
        ir = {3'b000, SUB, 11'b0}; sel_B = 1'b1; en_C = 1'b1; en_status = 1'b1;
        step();
        fz = 1'b0; fn = 1'b0; fv = 1'b0;
        expect_c("rst_vs_enc", 16'h0000);
        read_reg("rst_clears_rf", 3'd4, 16'h0000);

        repeat (3) @(posedge clk);
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Execution datapath for the 16-bit RISC CPU, on the receiving end of the controller's control bus.
- Holds:
  - an 8x16 register file,
  - operand registers A and B,
  - a shifter and ALU,
  - result register C,
  - status flags Z/N/V.
- Decodes register numbers and immediates from the current instruction word.
- Executes whatever the controller asserts in the same cycle: no handshake, the controller owns sequencing.

Parameters:
- DW, 16, datapath and register width
- NREG, 8, register-file depth (register index = 3 bits)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- ir  in  16  instruction register contents
- mdata  in  DW  RAM read data
- pc  in  8  program counter, write-back source
- reg_sel  in  2  register select: 10=Rn, 01=Rm, 00=Rd, 11=none
- wb_sel  in  2  write-back source: 00=C, 01=zero-extended pc, 10=sximm8, 11=mdata
- w_en  in  1  register-file write enable
- en_A, en_B, en_C, en_status  in  1 each  load enables
- sel_A  in  1  1: ALU A input = 0; 0: A register
- sel_B  in  1  1: ALU B input = sximm5; 0: shifted B register
- datapath_out  out  DW  C register (RAM address/data, debug)
- Z, N, V  out  1 each  status flags

Behaviour:
- Instruction field decode (combinational):
  - Rn=ir[10:8], Rd=ir[7:5], Rm=ir[2:0]
  - alu_op=ir[12:11], shift=ir[4:3]
  - sximm8 = sign-extended ir[7:0]
  - sximm5 = sign-extended ir[4:0]
- Register index: chosen by reg_sel. Both read and write use the same index.
- reg_sel=11 suppresses any write even with w_en=1. Read data is then don't-care.
- Register file:
  - Combinational read.
  - Write at posedge when w_en=1 and reg_sel!=11.
  - Same-cycle read/write of the same register: A/B capture the OLD value (read-before-write).
- Write-back data: mux per wb_sel.
  - pc is zero-extended to DW.
  - C used for write-back is the value registered before this edge.
- A, B, C:
  - Load at posedge when their enable is 1, otherwise hold.
  - A and B load the register-file read data.
  - C loads the ALU result.
- Shifter, applied to B only:
  - 00 pass
  - 01 LSL1, 0 in
  - 10 LSR1, 0 in
  - 11 ASR1, msb replicated
  - The shifter is ignored when sel_B=1.
- ALU, on Ain/Bin:
  - 00 ADD (mod 2^16)
  - 01 SUB (Ain-Bin, used by CMP)
  - 10 AND
  - 11 NOT Bin (MVN)
- Flags, computed from the ALU result:
  - Z = (result==0)
  - N = result[15]
  - V = signed overflow for ADD/SUB, 0 for AND/NOT
  - Z/N/V load together at posedge when en_status=1, otherwise hold.
- en_C and en_status may assert together; both load from the same result.
- Latency: one clock from enable to register output. datapath_out valid the cycle after en_C.
- Reset (rst=1 at posedge):
  - All 8 registers, A, B, C = 0; Z=N=V=0.
  - Reset dominates all enables in the same cycle.
  - Reset mid-instruction discards partial state; no recovery behaviour required.
- No X propagation: an undefined reg_sel/wb_sel combination never occurs, since all 2-bit codes are defined.

Decomposition:
- cpu_pkg holds:
  - enums reg_sel_t (RD=00, RM=01, RN=10, NONE=11)
  - wb_sel_t (WB_C, WB_PC, WB_IMM8, WB_MDATA)
  - alu_op_t (ADD, SUB, AND, MVN)
  - shift_t (NOSH, LSL, LSR, ASR)
  - constants DW=16, NREG=8
  - These are shared with the controller.
- One sub-module: regfile (8x16, sync write, comb read).
- Shifter and ALU stay inline in the datapath.

Test Plan:
- Reset then idle → all outputs 0. Write R3 via wb_sel=10, ir=0xD37F (Rn=3, imm8=0x7F), reg_sel=10, w_en=1 → R3=0x007F next cycle.
- ADD path:
  - Stimulus: R1=5, R2=0xFFFD; load A from Rn=1, load B from Rm=2; alu_op=00, shift=00, sel_A=0, sel_B=0, en_C=1; write Rd via wb_sel=00.
  - Response: datapath_out=0x0002, Rd=2.
- CMP flags:
  - A=0x7FFF, B=0xFFFF, alu_op=01, en_status=1 → result 0x8000, Z=0, N=1, V=1.
  - A=B=0x1234 → Z=1, N=0, V=0.
- Shifts: B=0x8001 with shift 01/10/11 (sel_A=1, ADD) → C=0x0002 / 0x4000 / 0xC000.
- LDR-style address:
  - A=0x0010, sel_B=1, ir[4:0]=5'b11110 (-2), ADD, en_C=1 → datapath_out=0x000E.
  - Then wb_sel=11, mdata=0xBEEF, w_en=1 → Rd=0xBEEF.
- Corners:
  - w_en with reg_sel=11 → no register changes.
  - Same-cycle write R4 and en_A reading R4 → A gets old R4.
  - rst asserted with en_C=1 → C=0.
